// File: rtl/phy_reg_free_list_pkg.sv
// phy_reg_free_list_pkg
//   Shared types and constants for the physical register free list.
//   The widths come from the project-wide PHYSICAL_REG_NUM_WIDTH and
//   MAX_NUM_OF_COMMITS defines. Defaults are supplied here only when the
//   surrounding build has not already defined them.
//   Optional feature macro used by the top: FREE_LIST_CHECK_EN.
`ifndef PHYSICAL_REG_NUM_WIDTH
`define PHYSICAL_REG_NUM_WIDTH 6
`endif
`ifndef MAX_NUM_OF_COMMITS
`define MAX_NUM_OF_COMMITS 2
`endif

package phy_reg_free_list_pkg;
  localparam int FL_PREG_W       = `PHYSICAL_REG_NUM_WIDTH;
  localparam int FL_COMMITS      = `MAX_NUM_OF_COMMITS;
  localparam int FL_ARCH_REG_NUM = 32;
  // Registers 0..ARCH-1 hold the reset mapping, so only the rest start free.
  localparam int FL_INIT_COUNT   = (2 ** FL_PREG_W) - FL_ARCH_REG_NUM;

  typedef enum logic {
    FL_INIT  = 1'b0,
    FL_READY = 1'b1
  } fl_state_t;
endpackage

// File: rtl/phy_reg_free_list_compactor.sv
// fl_release_compactor
//   Combinational packing of the commit lanes that release a register.
//   A lane qualifies when commit_valid & commit_with_write. Qualifying lanes
//   are packed in lane order (lane 0 first) into rel_list[0..rel_n-1].
// Ports:
//   commit_valid         in  per-lane commit valid
//   commit_with_write    in  per-lane "instruction wrote a register"
//   commited_wr_register in  per-lane released register number
//   rel_list             out packed release list, slot 0 first
//   rel_n                out number of valid slots in rel_list
module fl_release_compactor
  import phy_reg_free_list_pkg::*;
#(
  parameter int W  = FL_PREG_W,
  parameter int N  = FL_COMMITS,
  parameter int NW = $clog2(N + 1)
) (
  input  logic [N-1:0]        commit_valid,
  input  logic [N-1:0]        commit_with_write,
  input  logic [N-1:0][W-1:0] commited_wr_register,
  output logic [N-1:0][W-1:0] rel_list,
  output logic [NW-1:0]       rel_n
);

  logic [N-1:0]         qual;
  logic [N-1:0][NW-1:0] pos;   // slot each lane lands in if it qualifies

  assign qual = commit_valid & commit_with_write;

  // Running prefix count: a lane's slot is the number of qualifying lanes
  // below it.
  always_comb begin
    logic [NW-1:0] acc;
    acc = '0;
    pos = '0;
    for (int i = 0; i < N; i++) begin
      pos[i] = acc;
      acc    = acc + NW'(qual[i]);
    end
    rel_n = acc;
  end

  // Slot-driven mux keeps every index a constant.
  always_comb begin
    rel_list = '0;
    for (int s = 0; s < N; s++)
      for (int i = 0; i < N; i++)
        if (qual[i] && pos[i] == NW'(s))
          rel_list[s] = commited_wr_register[i];
  end

endmodule

// File: rtl/phy_reg_free_list.sv
// phy_reg_free_list
//   Circular free list of physical register numbers for the renamer.
//   After reset it spends one cycle per entry loading ARCH_REG_NUM..2**W-1
//   (INIT), then grants one register per cycle from the head and appends up
//   to MAX_NUM_OF_COMMITS released registers per cycle at the tail.
//   retire_head trails head by the allocations not yet committed; a flush
//   rewinds head to it, returning those registers to the pool.
//   Optional feature: define FREE_LIST_CHECK_EN to add the sticky fl_error
//   output (overflowing release, double release of an initially mapped
//   register, alloc_req before ready).
// Ports:
//   clk, reset           clock, synchronous active-high reset
//   alloc_req            renamer wants a destination register
//   alloc_valid          grant; the head pops at the clock edge
//   alloc_phy_reg        entry at the head (valid when can_rename)
//   can_rename           ready and list not empty
//   commit_valid         per-lane commit valid
//   commit_with_write    per-lane commit released a register
//   commited_wr_register per-lane released register number
//   flush                pipeline flush
//   ready                initialisation complete
//   free_count           number of free entries
//   fl_error             (FREE_LIST_CHECK_EN only) sticky protocol error
module phy_reg_free_list
  import phy_reg_free_list_pkg::*;
#(
  parameter int PHYSICAL_REG_NUM_WIDTH = FL_PREG_W,
  parameter int ARCH_REG_NUM           = FL_ARCH_REG_NUM,
  parameter int MAX_NUM_OF_COMMITS     = FL_COMMITS
) (
  input  logic                                                clk,
  input  logic                                                reset,
  input  logic                                                alloc_req,
  output logic                                                alloc_valid,
  output logic [PHYSICAL_REG_NUM_WIDTH-1:0]                   alloc_phy_reg,
  output logic                                                can_rename,
  input  logic [MAX_NUM_OF_COMMITS-1:0]                       commit_valid,
  input  logic [MAX_NUM_OF_COMMITS-1:0]                       commit_with_write,
  input  logic [MAX_NUM_OF_COMMITS-1:0][PHYSICAL_REG_NUM_WIDTH-1:0] commited_wr_register,
  input  logic                                                flush,
  output logic                                                ready,
`ifdef FREE_LIST_CHECK_EN
  output logic                                                fl_error,
`endif
  output logic [PHYSICAL_REG_NUM_WIDTH:0]                     free_count
);

  localparam int W        = PHYSICAL_REG_NUM_WIDTH;
  localparam int N        = MAX_NUM_OF_COMMITS;
  localparam int DEPTH    = 2 ** W;
  localparam int INIT_CNT = DEPTH - ARCH_REG_NUM;
  localparam int NW       = $clog2(N + 1);

  fl_state_t      state;
  logic [W-1:0]   mem [DEPTH];
  logic [W-1:0]   head, tail, retire_head;
  logic [W:0]     count;

  logic [N-1:0][W-1:0] rel_list;
  logic [NW-1:0]       rel_n;
  logic [W-1:0]        tail_next, retire_next;
  logic [W:0]          count_next;

  fl_release_compactor #(.W(W), .N(N), .NW(NW)) u_compactor (
    .commit_valid         (commit_valid),
    .commit_with_write    (commit_with_write),
    .commited_wr_register (commited_wr_register),
    .rel_list             (rel_list),
    .rel_n                (rel_n)
  );

  assign ready         = (state == FL_READY);
  assign can_rename    = ready & (count != '0);
  // Flush wins over a same-cycle request.
  assign alloc_valid   = alloc_req & can_rename & ~flush;
  assign alloc_phy_reg = mem[head];
  assign free_count    = count;

  assign tail_next   = tail + W'(rel_n);
  assign retire_next = retire_head + W'(rel_n);
  assign count_next  = count + (W+1)'(rel_n) - (W+1)'(alloc_valid);

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= FL_INIT;
      head        <= '0;
      tail        <= '0;
      retire_head <= '0;
      count       <= '0;
      mem[0]      <= '0;
    end else begin
      case (state)
        FL_INIT: begin
          // tail doubles as the init index: entry[i] = ARCH + i.
          mem[tail] <= W'(ARCH_REG_NUM) + tail;
          tail      <= tail + 1'b1;
          count     <= count + 1'b1;
          if (count == (W+1)'(INIT_CNT - 1))
            state <= FL_READY;
        end
        FL_READY: begin
          for (int k = 0; k < N; k++)
            if (rel_n > NW'(k))
              mem[tail + W'(k)] <= rel_list[k];
          tail        <= tail_next;
          retire_head <= retire_next;
          if (flush) begin
            // Everything between the (post-commit) retire point and the new
            // tail is free again.
            head  <= retire_next;
            count <= {1'b0, tail_next - retire_next};
          end else begin
            head  <= head + W'(alloc_valid);
            count <= count_next;
          end
        end
        default: state <= FL_INIT;
      endcase
    end
  end

`ifdef FREE_LIST_CHECK_EN
  // Bit set = register currently mapped. Registers below ARCH start mapped
  // by the reset map, so a release of one that is already clear means it
  // was freed twice without being handed out in between.
  logic [DEPTH-1:0] allocated;
  logic [W+1:0]     grow;
  logic [W:0]       arch_lim;

  assign grow     = {1'b0, count} + (W+2)'(rel_n) - (W+2)'(alloc_valid);
  assign arch_lim = (W+1)'(ARCH_REG_NUM);

  always_ff @(posedge clk) begin
    if (reset) begin
      fl_error  <= 1'b0;
      allocated <= '0;
      for (int i = 0; i < ARCH_REG_NUM; i++)
        allocated[i] <= 1'b1;
    end else begin
      if (alloc_req && !ready)
        fl_error <= 1'b1;
      if (ready) begin
        if (grow > (W+2)'(INIT_CNT))
          fl_error <= 1'b1;
        for (int k = 0; k < N; k++)
          if (rel_n > NW'(k) && ({1'b0, rel_list[k]} < arch_lim) &&
              !allocated[rel_list[k]])
            fl_error <= 1'b1;
        if (alloc_valid)
          allocated[alloc_phy_reg] <= 1'b1;
        for (int k = 0; k < N; k++)
          if (rel_n > NW'(k))
            allocated[rel_list[k]] <= 1'b0;
      end
    end
  end
`endif

endmodule

// File: tb/tb_phy_reg_free_list.sv
module tb_phy_reg_free_list;
  import phy_reg_free_list_pkg::*;

  localparam int W = FL_PREG_W;
  localparam int N = FL_COMMITS;

  logic                clk = 1'b0;
  logic                reset = 1'b1;
  logic                alloc_req = 1'b0;
  logic                flush = 1'b0;
  logic [N-1:0]        commit_valid = '0;
  logic [N-1:0]        commit_with_write = '0;
  logic [N-1:0][W-1:0] commited_wr_register = '0;
  logic                alloc_valid, can_rename, ready;
  logic [W-1:0]        alloc_phy_reg;
  logic [W:0]          free_count;

  int total = 0;
  int bad   = 0;
  int expq[$];
  int cyc;

  phy_reg_free_list dut (
    .clk                  (clk),
    .reset                (reset),
    .alloc_req            (alloc_req),
    .alloc_valid          (alloc_valid),
    .alloc_phy_reg        (alloc_phy_reg),
    .can_rename           (can_rename),
    .commit_valid         (commit_valid),
    .commit_with_write    (commit_with_write),
    .commited_wr_register (commited_wr_register),
    .flush                (flush),
    .ready                (ready),
`ifdef FREE_LIST_CHECK_EN
    .fl_error             (),
`endif
    .free_count           (free_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (!ready && n < 100) begin
      tick();
      n++;
    end
  endtask

  task automatic rel(input logic [N-1:0] v, input int r0, input int r1);
    commit_valid            = v;
    commit_with_write       = v;
    commited_wr_register[0] = W'(r0);
    commited_wr_register[1] = W'(r1);
  endtask

  task automatic rel_clr();
    commit_valid      = '0;
    commit_with_write = '0;
  endtask

  // Monitor: every grant must match the oldest expected register.
  initial begin
    forever begin
      @(negedge clk);
      if (!reset && alloc_valid) begin
        total++;
        if (expq.size() == 0) begin
          bad++;
          $display("FAIL grant_unexpected got=%0d want=none", alloc_phy_reg);
        end else begin
          int e;
          e = expq.pop_front();
          if (int'(alloc_phy_reg) != e) begin
            bad++;
            $display("FAIL grant got=%0d want=%0d", alloc_phy_reg, e);
          end
        end
      end
    end
  end

  initial begin
    // Reset state
    tick(); tick(); tick();
    chk("rst_ready", ready, 0);
    chk("rst_can_rename", can_rename, 0);
    chk("rst_alloc_valid", alloc_valid, 0);
    chk("rst_free_count", free_count, 0);
    chk("rst_alloc_phy_reg", alloc_phy_reg, 0);

    // Init takes 32 cycles
    reset = 1'b0;
    wait_ready(cyc);
    chk("init_cycles", cyc, 32);
    chk("init_free_count", free_count, 32);
    chk("init_head", alloc_phy_reg, 32);

    // Drain the whole list: grants 32..63
    alloc_req = 1'b1;
    for (int i = 0; i < 32; i++) begin
      expq.push_back(32 + i);
      tick();
    end
    chk("empty_can_rename", can_rename, 0);
    chk("empty_free_count", free_count, 0);
    chk("empty_no_grant", alloc_valid, 0);

    // Release 40,41 on an empty list while requesting: no bypass
    rel(2'b11, 40, 41);
    #1;
    chk("empty_rel_no_grant", alloc_valid, 0);
    tick();
    rel_clr();
    alloc_req = 1'b0;
    #1;
    chk("rel2_head", alloc_phy_reg, 40);
    chk("rel2_free_count", free_count, 2);

    // Lane 1 only releases 50 (lane 0 data is ignored)
    rel(2'b10, 7, 50);
    tick();
    rel_clr();
    #1;
    chk("lane1_free_count", free_count, 3);
    alloc_req = 1'b1;
    expq.push_back(40); expq.push_back(41); expq.push_back(50);
    repeat (3) tick();
    alloc_req = 1'b0;
    #1;
    chk("lane1_drain_free_count", free_count, 0);

    // Reset at INIT cycle 10, re-init from scratch
    reset = 1'b1;
    tick();
    reset = 1'b0;
    repeat (10) tick();
    reset = 1'b1;
    tick(); tick();
    chk("rst_init_ready", ready, 0);
    reset = 1'b0;
    wait_ready(cyc);
    chk("reinit_cycles", cyc, 32);
    chk("reinit_free_count", free_count, 32);

    // Allocate 5, then flush with two same-cycle commits
    alloc_req = 1'b1;
    for (int i = 0; i < 5; i++) begin
      expq.push_back(32 + i);
      tick();
    end
    alloc_req = 1'b0;
    #1;
    chk("alloc5_free_count", free_count, 27);
    alloc_req = 1'b1;
    flush = 1'b1;
    rel(2'b11, 3, 7);
    #1;
    chk("flush_blocks_grant", alloc_valid, 0);
    tick();
    alloc_req = 1'b0;
    flush = 1'b0;
    rel_clr();
    #1;
    // tail 32+2=34, retire 2 -> 32 free; head rewound to entry[2]=34
    chk("flush_free_count", free_count, 32);
    chk("flush_head", alloc_phy_reg, 34);

    // One grant, its commit, then a flush with nothing in flight
    alloc_req = 1'b1;
    expq.push_back(34);
    tick();
    alloc_req = 1'b0;
    rel(2'b01, 9, 0);
    tick();
    rel_clr();
    #1;
    chk("commit1_free_count", free_count, 32);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    #1;
    chk("noop_flush_free_count", free_count, 32);
    chk("noop_flush_head", alloc_phy_reg, 35);

    // Drain to count=1 (entries 3..31 hold 35..63, then 3,7 appended)
    alloc_req = 1'b1;
    for (int i = 3; i < 32; i++) expq.push_back(32 + i);
    expq.push_back(3);
    expq.push_back(7);
    repeat (31) tick();
    #1;
    chk("count1_free_count", free_count, 1);
    // Grant the last entry while releasing 20 the same cycle
    expq.push_back(9);
    rel(2'b01, 20, 0);
    tick();
    rel_clr();
    alloc_req = 1'b0;
    #1;
    chk("count1_rel_free_count", free_count, 1);
    chk("count1_rel_head", alloc_phy_reg, 20);

    // Reset during a flush
    flush = 1'b1;
    reset = 1'b1;
    tick();
    flush = 1'b0;
    #1;
    chk("rst_flush_ready", ready, 0);
    chk("rst_flush_free_count", free_count, 0);
    tick();
    reset = 1'b0;
    wait_ready(cyc);
    chk("rst_flush_reinit_cycles", cyc, 32);
    chk("rst_flush_head", alloc_phy_reg, 32);

    tick();
    chk("expected_grants_left", expq.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
